// File: rtl/cpu_run_ctrl_if.sv
// Debug read handshake between a requester (master) and the run controller (slave).
interface cpu_run_ctrl_if;
  logic        rd_req;
  logic [7:0]  rd_addr;
  logic        rd_ready;
  logic        rd_valid;
  logic [31:0] rd_data;

  modport master (
    output rd_req,
    output rd_addr,
    input  rd_ready,
    input  rd_valid,
    input  rd_data
  );

  modport slave (
    input  rd_req,
    input  rd_addr,
    output rd_ready,
    output rd_valid,
    output rd_data
  );
endinterface

// File: rtl/cpu_run_ctrl.sv
// Execution sequencer for the single-cycle CPU: run/step/halt, PC breakpoint,
// instruction watchdog, and debug reads of RF/DM that are only served while halted.
module cpu_run_ctrl #(
  parameter int MAX_CYCLES = 100,
  parameter int CNT_W      = 32
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                run_req,
  input  logic                step_req,
  input  logic                halt_req,
  input  logic                bp_en,
  input  logic [31:0]         bp_addr,
  input  logic [31:0]         cpu_pc,
  output logic                cpu_en,
  cpu_run_ctrl_if.slave       rd,
  output logic [7:0]          dm_rf_addr,
  input  logic [31:0]         dm_rf_data,
  output logic [1:0]          state,
  output logic [CNT_W-1:0]    inst_cnt,
  output logic                bp_hit,
  output logic                timeout
);

  typedef enum logic [1:0] {
    S_HALT = 2'd0,
    S_RUN  = 2'd1,
    S_STEP = 2'd2,
    S_READ = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_CYCLES);

  state_t            state_reg;
  logic              skip_reg;
  logic              bp_hit_reg;
  logic              timeout_reg;
  logic              rd_valid_reg;
  logic [31:0]       rd_data_reg;
  logic [7:0]        addr_reg;
  logic [CNT_W-1:0]  cnt_reg;

  logic brk;
  logic cpu_en_int;
  logic rd_ready_int;
  logic wd_hit;

  // skip lets a resume from a breakpoint PC execute that instruction once.
  assign brk          = bp_en & (cpu_pc == bp_addr) & ~skip_reg;
  assign cpu_en_int   = (state_reg == S_STEP) |
                        ((state_reg == S_RUN) & ~halt_req & ~brk);
  assign rd_ready_int = (state_reg == S_HALT) & ~step_req & ~run_req;
  assign wd_hit       = cpu_en_int & (cnt_reg == CNT_LAST);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg    <= S_HALT;
      skip_reg     <= 1'b0;
      bp_hit_reg   <= 1'b0;
      timeout_reg  <= 1'b0;
      rd_valid_reg <= 1'b0;
      rd_data_reg  <= 32'd0;
      addr_reg     <= 8'd0;
      cnt_reg      <= '0;
    end else begin
      rd_valid_reg <= 1'b0;
      if (cpu_en_int && (cnt_reg != CNT_MAX)) begin
        cnt_reg <= cnt_reg + 1'b1;
      end

      case (state_reg)
        S_HALT: begin
          if (step_req && !timeout_reg) begin
            state_reg <= S_STEP;
          end else if (run_req && !timeout_reg) begin
            state_reg  <= S_RUN;
            skip_reg   <= 1'b1;
            bp_hit_reg <= 1'b0;
          end else if (rd.rd_req && rd_ready_int) begin
            state_reg <= S_READ;
            addr_reg  <= rd.rd_addr;
          end
        end
        S_STEP: state_reg <= S_HALT;
        S_RUN: begin
          skip_reg <= 1'b0;
          if (halt_req) begin
            state_reg <= S_HALT;
          end else if (brk) begin
            state_reg  <= S_HALT;
            bp_hit_reg <= 1'b1;
          end
        end
        S_READ: begin
          rd_data_reg  <= dm_rf_data;
          rd_valid_reg <= 1'b1;
          state_reg    <= S_HALT;
        end
        default: state_reg <= S_HALT;
      endcase

      // Watchdog stop overrides whatever RUN/STEP decided this cycle.
      if (wd_hit) begin
        state_reg   <= S_HALT;
        timeout_reg <= 1'b1;
      end
    end
  end

  assign cpu_en      = cpu_en_int;
  assign rd.rd_ready = rd_ready_int;
  assign rd.rd_valid = rd_valid_reg;
  assign rd.rd_data  = rd_data_reg;
  assign dm_rf_addr  = addr_reg;
  assign state       = state_reg;
  assign inst_cnt    = cnt_reg;
  assign bp_hit      = bp_hit_reg;
  assign timeout     = timeout_reg;

endmodule
